// File: rtl/banner_pkg.sv
// ============================================================================
// Module   : banner_pkg
// Purpose  : Shared types and constants for the game-event banner sequencer,
//            glyph renderers and pixel mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package banner_pkg;

   localparam int COORD_W      = 10;
   localparam int GLYPH_WIDTH  = 32;
   localparam int GLYPH_HEIGHT = 40;
   localparam int SCREEN_H     = 480;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REVEAL = 3'd1,
      ST_DROP   = 3'd2,
      ST_BLINK  = 3'd3,
      ST_HOLD   = 3'd4
   } banner_state_e;

endpackage

`default_nettype wire

// File: rtl/banner_seq_ctrl_frame_div.sv
// ============================================================================
// Module   : frame_div
// Purpose  : Frame-tick divider; pulse marks every DIV-th tick while not cleared.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic pulse
);

   localparam int            c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               w_at_last;

   assign w_at_last = (r_cnt == c_LAST);
   assign pulse     = tick & ~clr & w_at_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= w_at_last ? '0 : r_cnt + c_CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/banner_seq_ctrl.sv
// ============================================================================
// Module   : banner_seq_ctrl
// Purpose  : Frame-synchronous reveal / drop / blink / hold sequencer for a
//            glyph banner. Macro BANNER_SEQ_BLINK_EN enables the blink phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module banner_seq_ctrl
   import banner_pkg::*;
#(
   parameter int                 N_GLYPH   = 8,
   parameter int                 GLYPH_W   = GLYPH_WIDTH,
   parameter logic [COORD_W-1:0] X_POS     = 10'd128,
   parameter logic [COORD_W-1:0] Y_START   = 10'd0,
   parameter logic [COORD_W-1:0] Y_FINAL   = 10'd200,
   parameter int                 STEP      = 16,
   parameter int                 BLINK_DIV = 2,
   parameter int                 BLINK_CNT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               req,
   output logic [COORD_W-1:0] x0,
   output logic [COORD_W-1:0] y0,
   output logic [N_GLYPH-1:0] glyph_en,
   output logic               busy,
   output logic               done
);

   // Elaboration-time sanity checks on the configuration.
   generate
      if (N_GLYPH < 2) begin : g_chk_n_glyph
         $error("banner_seq_ctrl: N_GLYPH must be at least 2");
      end
      if (int'(X_POS) + N_GLYPH * GLYPH_W > (1 << COORD_W)) begin : g_chk_width
         $error("banner_seq_ctrl: banner does not fit in the x range");
      end
      if ((Y_FINAL < Y_START) || (int'(Y_FINAL) + GLYPH_HEIGHT > SCREEN_H)) begin : g_chk_rows
         $error("banner_seq_ctrl: bad Y_START/Y_FINAL");
      end
      if (STEP < 1) begin : g_chk_step
         $error("banner_seq_ctrl: STEP must be positive");
      end
      if ((BLINK_DIV < 1) || (BLINK_CNT < 2) || ((BLINK_CNT % 2) != 0)) begin : g_chk_blink
         $error("banner_seq_ctrl: BLINK_CNT must be even and BLINK_DIV positive");
      end
   endgenerate

   localparam logic [COORD_W:0] c_STEP    = (COORD_W + 1)'(STEP);
   localparam logic [COORD_W:0] c_Y_FINAL = {1'b0, Y_FINAL};
`ifdef BANNER_SEQ_BLINK_EN
   localparam banner_state_e    c_DROP_EXIT = ST_BLINK;
`else
   localparam banner_state_e    c_DROP_EXIT = ST_HOLD;
`endif

   banner_state_e      r_state, w_state_nxt;
   logic [N_GLYPH-1:0] r_glyph_en, w_glyph_nxt, w_glyph_shift;
   logic [COORD_W-1:0] r_y0, w_y0_nxt;
   logic [COORD_W:0]   w_sum;
   logic               r_busy, r_done;
   logic               w_active;

   // Sum carried one bit wider so the clamp never sees a wrapped value.
   assign w_sum         = {1'b0, r_y0} + c_STEP;
   assign w_glyph_shift = {r_glyph_en[N_GLYPH-2:0], 1'b1};
   assign w_active      = (r_state == ST_REVEAL) || (r_state == ST_DROP) ||
                          (r_state == ST_BLINK);

`ifdef BANNER_SEQ_BLINK_EN
   localparam int                 c_TOG_W    = $clog2(BLINK_CNT + 1);
   localparam logic [c_TOG_W-1:0] c_TOG_LAST = c_TOG_W'(BLINK_CNT);

   logic [c_TOG_W-1:0] r_tog_cnt, w_tog_nxt;
   logic               w_div_clr, w_div_tick, w_blink_pulse;

   // While req is low the divider is frozen along with everything else.
   assign w_div_clr  = (r_state != ST_BLINK);
   assign w_div_tick = frame_tick & req;

   frame_div #(
      .DIV (BLINK_DIV)
   ) u_frame_div (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_div_clr),
      .tick  (w_div_tick),
      .pulse (w_blink_pulse)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tog_cnt <= '0;
      end else begin
         r_tog_cnt <= w_tog_nxt;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_glyph_nxt = r_glyph_en;
      w_y0_nxt    = r_y0;
`ifdef BANNER_SEQ_BLINK_EN
      w_tog_nxt   = (r_state == ST_BLINK) ? r_tog_cnt : '0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_glyph_nxt = '0;
            w_y0_nxt    = Y_START;
            if (req) begin
               w_state_nxt = ST_REVEAL;
            end
         end
         ST_REVEAL: begin
            if (frame_tick) begin
               w_glyph_nxt = w_glyph_shift;
               if (&w_glyph_shift) begin
                  w_state_nxt = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (frame_tick) begin
               if (w_sum >= c_Y_FINAL) begin
                  w_y0_nxt    = Y_FINAL;
                  w_state_nxt = c_DROP_EXIT;
               end else begin
                  w_y0_nxt = w_sum[COORD_W-1:0];
               end
            end
         end
`ifdef BANNER_SEQ_BLINK_EN
         ST_BLINK: begin
            if (w_blink_pulse) begin
               w_glyph_nxt = ~r_glyph_en;
               w_tog_nxt   = r_tog_cnt + c_TOG_W'(1);
               if (w_tog_nxt == c_TOG_LAST) begin
                  w_glyph_nxt = '1;
                  w_state_nxt = ST_HOLD;
               end
            end
         end
`endif
         ST_HOLD: begin
            w_glyph_nxt = '1;
            w_y0_nxt    = Y_FINAL;
            if (!req) begin
               w_state_nxt = ST_IDLE;
               w_glyph_nxt = '0;
               w_y0_nxt    = Y_START;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_glyph_nxt = '0;
            w_y0_nxt    = Y_START;
         end
      endcase

      // Abort takes effect only on a frame boundary; until then nothing moves.
      if (w_active && frame_tick && !req) begin
         w_state_nxt = ST_IDLE;
         w_glyph_nxt = '0;
         w_y0_nxt    = Y_START;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_glyph_en <= '0;
         r_y0       <= Y_START;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_glyph_en <= w_glyph_nxt;
         r_y0       <= w_y0_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= (w_state_nxt == ST_HOLD);
      end
   end

   assign x0       = X_POS;
   assign y0       = r_y0;
   assign glyph_en = r_glyph_en;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

`default_nettype wire
